dm_unit: RTL and testbench
==========================

DM_UNIT -- requirements
Module: dm_unit

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words in the data array; power of two.
REQ-002 Parameter IDX_W, default 10, word-index width, equal to log2(DEPTH_WORDS).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 addr  input  32  byte address from ALUOut; bits [IDX_W+1:2] select the word, bits [1:0] select the lane, and higher bits are ignored (wrap).
REQ-006 wdata  input  32  store data from register B.
REQ-007 MemWrite  input  1  store strobe from control FSM; one cycle per store.
REQ-008 lsop  input  2  access size: WORDop=2'b00, HALFop=2'b01, BYTEop=2'b10, 2'b11 reserved.
REQ-009 dmEXTop  input  1  load extension: 0 = sign-extend, 1 = zero-extend (lbu/lhu).
REQ-010 mdr  output  32  registered load data (memory data register) feeding the MemtoReg mux.
REQ-011 busy  output  1  high while the post-reset clear sweep runs; top level holds the control FSM while high.
REQ-012 misalign  output  1  sticky store-fault flag.

Function
REQ-013 Two-state FSM: CLEAR, IDLE; a 1-bit state register plus an IDX_W-bit sweep pointer ptr.
REQ-014 CLEAR: each cycle with rst low, write 32'h0 to word ptr and increment ptr; after writing word DEPTH_WORDS-1, go to IDLE.
REQ-015 busy = 1 exactly when the state is CLEAR; the sweep takes DEPTH_WORDS cycles after rst deasserts.
REQ-016 In CLEAR, MemWrite is ignored and mdr holds its value.
REQ-017 IDLE: mdr updates every cycle (latency 1 from addr/lsop/dmEXTop) with the load result for the current inputs, independent of MemWrite.
REQ-018 Lane order is little-endian: byte k occupies word bits [8k+7:8k].
REQ-019 Byte load selects lane addr[1:0], and half load selects halfword addr[1] with addr[0] ignored.
REQ-020 Word load, and load with lsop=2'b11, returns the whole word with addr[1:0] ignored.
REQ-021 Byte and half loads extend to 32 bits per dmEXTop.
REQ-022 Store in IDLE with MemWrite=1:
- word: writes all 4 bytes.
- half: writes the bytes of halfword addr[1].
- byte: writes lane addr[1:0] with wdata[7:0].
- Half uses wdata[15:0].
- All other bytes are untouched.
REQ-023 Store fault:
- Fault conditions: word with addr[1:0]!=0; half with addr[0]=1; lsop=2'b11.
- Effect: the write is suppressed and misalign is set to 1.
- misalign stays 1 until rst.
REQ-024 A load and a store to the same word in the same cycle return read-before-write: mdr receives the old contents.
REQ-025 Loads never set misalign.

Reset
REQ-026 While rst=1: state=CLEAR, ptr=0, busy=1, mdr=32'h0, misalign=0, and no array writes occur.
REQ-027 rst asserted mid-sweep or mid-operation restarts the sweep from ptr=0 on the next cycle.
REQ-028 The array is initialised only by the sweep, never by rst directly.

Structure
REQ-029 The lsop encodings (WORDop, HALFop, BYTEop) and the dmEXTop meanings live in the shared store-definition constants file used by the control FSM.
REQ-030 The FSM state encodings are local to dm_unit.
REQ-031 One sub-module, dm_ext: combinational lane select and sign/zero extension (rdword, addr[1:0], lsop, dmEXTop -> 32-bit result).
REQ-032 The array is an inferred single-write-port register array.

Verification
REQ-033 Reset and sweep:
- Stimulus: rst high 3 cycles, then low.
- Required: busy=1 for exactly 1024 cycles after deassert, then 0.
- Then: word load at 0x0 and at 0xFFC gives mdr=0.
REQ-034 Word store and extended loads:
- Stimulus: sw 0x8081F2F3 at 0x10.
- lb 0x10 gives mdr=0xFFFFFFF3; lbu 0x13 gives 0x00000080.
- lh 0x12 gives 0xFFFF8081; lhu 0x10 gives 0x0000F2F3.
REQ-035 Partial stores:
- Stimulus: after sw 0 to 0x20, sb 0xAB at 0x22, then sh 0x1234 at 0x20.
- Required: lw 0x20 gives 0x00AB1234.
REQ-036 Store faults:
- Stimulus: sw at 0x21, then sh at 0x23.
- Required: word 0x20 unchanged and misalign=1 from the first fault onward.
- Then: rst clears misalign to 0.
REQ-037 Read-before-write and reset mid-sweep:
- Stimulus: sw 0xDEADBEEF at 0x40 while loading 0x40.
- Required: mdr shows the old value that cycle, and 0xDEADBEEF on the next load.
- Then: rst pulse at sweep cycle 500 restarts busy for the full 1024 cycles.

Source files
------------

// File: rtl/dm_unit_pkg.sv
// Shared store/load definitions for the data memory unit.
// Access-size codes, extension modes and store byte-enable helpers.
package dm_unit_pkg;

  localparam logic [1:0] WORDop = 2'b00;
  localparam logic [1:0] HALFop = 2'b01;
  localparam logic [1:0] BYTEop = 2'b10;
  localparam logic [1:0] RSVDop = 2'b11;

  localparam logic EXT_SIGN = 1'b0;
  localparam logic EXT_ZERO = 1'b1;

  function automatic logic st_fault(
    input logic [1:0] op,
    input logic [1:0] lane
  );
    logic f;
    f = 1'b0;
    case (op)
      WORDop:  f = (lane != 2'b00);
      HALFop:  f = lane[0];
      BYTEop:  f = 1'b0;
      default: f = 1'b1;
    endcase
    return f;
  endfunction

  function automatic logic [3:0] st_mask(
    input logic [1:0] op,
    input logic [1:0] lane
  );
    logic [3:0] m;
    m = 4'h0;
    case (op)
      WORDop:  m = 4'hF;
      HALFop:  m = lane[1] ? 4'hC : 4'h3;
      BYTEop:  m = 4'b0001 << lane;
      default: m = 4'h0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dm_ext.sv
// Load lane select and sign/zero extension.
// Ports: rdword (raw word), lane (addr[1:0]), lsop, dmEXTop -> result.
module dm_ext
  import dm_unit_pkg::*;
(
  input  logic [31:0] rdword,
  input  logic [1:0]  lane,
  input  logic [1:0]  lsop,
  input  logic        dmEXTop,
  output logic [31:0] result
);

  logic [7:0]  w_b;
  logic [15:0] w_h;
  logic        w_sgn;

  assign w_b   = rdword[{lane, 3'b000} +: 8];
  assign w_h   = lane[1] ? rdword[31:16] : rdword[15:0];
  assign w_sgn = (dmEXTop == EXT_SIGN);

  always_comb begin
    result = rdword;
    case (lsop)
      BYTEop:  result = {{24{w_b[7] & w_sgn}}, w_b};
      HALFop:  result = {{16{w_h[15] & w_sgn}}, w_h};
      default: result = rdword;
    endcase
  end

endmodule

// File: rtl/dm_unit.sv
// Data memory: post-reset clear sweep, byte/half/word loads and stores.
// Ports: clk, rst, addr, wdata, MemWrite, lsop, dmEXTop -> mdr, busy, misalign.
module dm_unit
  import dm_unit_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        MemWrite,
  input  logic [1:0]  lsop,
  input  logic        dmEXTop,
  output logic [31:0] mdr,
  output logic        busy,
  output logic        misalign
);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [31:0]      r_mdr;
  logic             r_misalign;
  logic [31:0]      r_mem [DEPTH_WORDS];

  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_lane;
  logic [31:0]      w_rd;
  logic [31:0]      w_ld;
  logic             w_fault;
  logic             w_we;
  logic [IDX_W-1:0] w_widx;
  logic [3:0]       w_be;
  logic [31:0]      w_wd;
  logic             w_unused;

  assign w_idx    = addr[IDX_W+1:2];
  assign w_lane   = addr[1:0];
  assign w_rd     = r_mem[w_idx];
  assign w_unused = &{1'b0, addr[31:IDX_W+2]};

  dm_ext u_ext (
    .rdword  (w_rd),
    .lane    (w_lane),
    .lsop    (lsop),
    .dmEXTop (dmEXTop),
    .result  (w_ld)
  );

  assign w_fault = (r_state == S_IDLE) & MemWrite
                 & st_fault(lsop, w_lane);

  // Sweep and stores share the single write port.
  always_comb begin
    w_we   = 1'b0;
    w_widx = w_idx;
    w_be   = 4'h0;
    w_wd   = 32'h0;
    if (r_state == S_CLEAR) begin
      w_we   = 1'b1;
      w_widx = r_ptr;
      w_be   = 4'hF;
      w_wd   = 32'h0;
    end else begin
      w_we = MemWrite & ~w_fault;
      w_be = st_mask(lsop, w_lane);
      case (lsop)
        HALFop:  w_wd = {2{wdata[15:0]}};
        BYTEop:  w_wd = {4{wdata[7:0]}};
        default: w_wd = wdata;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_we) begin
      for (int k = 0; k < 4; k++) begin
        if (w_be[k]) r_mem[w_widx][8*k +: 8] <= w_wd[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_CLEAR;
      r_ptr      <= '0;
      r_mdr      <= 32'h0;
      r_misalign <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == IDX_W'(DEPTH_WORDS - 1)) r_state <= S_IDLE;
        end
        default: begin
          r_mdr <= w_ld;
          if (w_fault) r_misalign <= 1'b1;
        end
      endcase
    end
  end

  assign mdr      = r_mdr;
  assign busy     = (r_state == S_CLEAR);
  assign misalign = r_misalign;

endmodule

// File: tb/tb_dm_unit.sv
// Scoreboard bench for dm_unit: loads push expected mdr into a queue,
// a monitor pops and compares one cycle after each issued load.
module tb_dm_unit;

  localparam logic [1:0] W  = 2'b00;
  localparam logic [1:0] H  = 2'b01;
  localparam logic [1:0] B  = 2'b10;
  localparam logic [1:0] RV = 2'b11;
  localparam logic SX = 1'b0;
  localparam logic ZX = 1'b1;

  typedef struct {
    string       nm;
    logic [31:0] exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        MemWrite = 1'b0;
  logic [1:0]  lsop = W;
  logic        dmEXTop = SX;
  logic [31:0] mdr;
  logic        busy;
  logic        misalign;

  logic        issue = 1'b0;
  exp_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;

  dm_unit dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .wdata    (wdata),
    .MemWrite (MemWrite),
    .lsop     (lsop),
    .dmEXTop  (dmEXTop),
    .mdr      (mdr),
    .busy     (busy),
    .misalign (misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Monitor: issue sampled at the edge, mdr compared just after it.
  initial begin
    forever begin
      logic v;
      exp_t e;
      @(posedge clk);
      v = issue;
      #1;
      if (v) begin
        if (q.size() == 0) begin
          chk("sb_empty", 32'd0, 32'd1);
        end else begin
          e = q.pop_front();
          chk(e.nm, mdr, e.exp);
        end
      end
    end
  end

  task automatic op(input logic [31:0] a, input logic [1:0] sz,
                    input logic e, input logic we,
                    input logic [31:0] d, input logic c,
                    input logic [31:0] exp, input string nm);
    exp_t x;
    addr     = a;
    lsop     = sz;
    dmEXTop  = e;
    MemWrite = we;
    wdata    = d;
    issue    = c;
    if (c) begin
      x.nm  = nm;
      x.exp = exp;
      q.push_back(x);
    end
    @(negedge clk);
    issue    = 1'b0;
    MemWrite = 1'b0;
  endtask

  task automatic ld(input logic [31:0] a, input logic [1:0] sz,
                    input logic e, input logic [31:0] exp,
                    input string nm);
    op(a, sz, e, 1'b0, 32'h0, 1'b1, exp, nm);
  endtask

  task automatic st(input logic [31:0] a, input logic [1:0] sz,
                    input logic [31:0] d);
    op(a, sz, SX, 1'b1, d, 1'b0, 32'h0, "");
  endtask

  task automatic sweep(input string nm);
    int cnt;
    cnt = 0;
    rst = 1'b0;
    while (cnt < 3000) begin
      @(negedge clk);
      cnt++;
      if (!busy) break;
    end
    chk(nm, 32'(cnt), 32'd1024);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_mdr", mdr, 32'h0);
    chk("rst_mis", 32'(misalign), 32'd0);

    sweep("sweep_len");
    chk("idle_busy", 32'(busy), 32'd0);

    ld(32'h0,    W, SX, 32'h0, "lw_0");
    ld(32'hFFC,  W, SX, 32'h0, "lw_ffc");

    st(32'h10, W, 32'h8081F2F3);
    ld(32'h10, B, SX, 32'hFFFFFFF3, "lb_10");
    ld(32'h13, B, ZX, 32'h00000080, "lbu_13");
    ld(32'h12, H, SX, 32'hFFFF8081, "lh_12");
    ld(32'h10, H, ZX, 32'h0000F2F3, "lhu_10");
    ld(32'h11, H, ZX, 32'h0000F2F3, "lhu_11");
    ld(32'h13, RV, SX, 32'h8081F2F3, "lrsv_13");
    ld(32'h1010, W, SX, 32'h8081F2F3, "lw_wrap");
    ld(32'h11, B, SX, 32'hFFFFFFF2, "lb_11");

    st(32'h20, W, 32'h0);
    st(32'h22, B, 32'hFFFFFFAB);
    st(32'h20, H, 32'hFFFF1234);
    ld(32'h20, W, SX, 32'h00AB1234, "lw_part");
    chk("mis_noload", 32'(misalign), 32'd0);

    st(32'h21, W, 32'h11111111);
    chk("mis_sw", 32'(misalign), 32'd1);
    st(32'h23, H, 32'h22222222);
    st(32'h20, RV, 32'h33333333);
    ld(32'h20, W, SX, 32'h00AB1234, "lw_fault");
    chk("mis_sticky", 32'(misalign), 32'd1);

    op(32'h40, W, SX, 1'b1, 32'hDEADBEEF, 1'b1, 32'h0, "rbw_old");
    ld(32'h40, W, SX, 32'hDEADBEEF, "rbw_new");

    rst = 1'b1;
    @(negedge clk);
    chk("rst2_mis", 32'(misalign), 32'd0);
    chk("rst2_mdr", mdr, 32'h0);
    chk("rst2_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    repeat (500) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    sweep("resweep_len");
    ld(32'h40, W, SX, 32'h0, "lw_cleared");
    ld(32'h20, W, SX, 32'h0, "lw_cleared2");

    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
